// File: rtl/frame_sec_mgr_if.sv
// Descriptor channel between the frame section manager and one DMA engine.
// The manager drives the descriptor and section; the DMA side drives load, ready and done.
interface frame_sec_mgr_if #(
  parameter int unsigned ADDR_W = 24,
  parameter int unsigned LEN_W  = 19,
  parameter int unsigned SEC_W  = 2
);
  logic              load;
  logic [ADDR_W-1:0] desc_addr;
  logic [LEN_W-1:0]  desc_len;
  logic              desc_valid;
  logic              desc_ready;
  logic              done;
  logic [SEC_W-1:0]  sec;

  modport master (
    input  load, desc_ready, done,
    output desc_addr, desc_len, desc_valid, sec
  );

  modport slave (
    output load, desc_ready, done,
    input  desc_addr, desc_len, desc_valid, sec
  );
endinterface

// File: rtl/frame_sec_mgr.sv
// Frame section manager: rotates a writer and a reader over NUM_SEC DDR frame
// sections, keeping the writer off the reader's section and tracking freshness.
module frame_sec_mgr #(
  parameter int unsigned NUM_SEC    = 4,
  parameter int unsigned MAX_LEN    = 518400,
  parameter int unsigned LEN_WIDTH  = $clog2(MAX_LEN),
  parameter int unsigned BANK_WIDTH = 3,
  parameter int unsigned BANK       = 0
) (
  input  logic            aclk,
  input  logic            aresetn,
  frame_sec_mgr_if.master wr_if,
  frame_sec_mgr_if.master rd_if,
  output logic            frame_avail,
  output logic [15:0]     drop_cnt,
  output logic [15:0]     repeat_cnt,
  output logic [15:0]     ovr_cnt
);
  localparam int unsigned SEC_WIDTH       = $clog2(NUM_SEC);
  localparam int unsigned DESC_ADDR_WIDTH = BANK_WIDTH + SEC_WIDTH + LEN_WIDTH;
  localparam int unsigned CNT_WIDTH       = 16;

  typedef enum logic [1:0] {W_IDLE, W_REQ, W_BUSY} wr_state_e;
  typedef enum logic [1:0] {R_IDLE, R_REQ, R_BUSY} rd_state_e;

  wr_state_e            wr_state_q, wr_state_d;
  rd_state_e            rd_state_q, rd_state_d;
  logic [SEC_WIDTH-1:0] wr_sec_q, wr_sec_d;
  logic [SEC_WIDTH-1:0] rd_sec_q, rd_sec_d;
  logic [SEC_WIDTH-1:0] last_sec_q, last_sec_d;
  logic                 any_done_q, any_done_d;
  logic                 fresh_q, fresh_d;
  logic                 wr_valid_q, wr_valid_d;
  logic                 rd_valid_q, rd_valid_d;
  logic                 wr_load_q, rd_load_q;
  logic [CNT_WIDTH-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_WIDTH-1:0] repeat_cnt_q, repeat_cnt_d;
  logic [CNT_WIDTH-1:0] ovr_cnt_q, ovr_cnt_d;

  logic wr_edge, rd_edge;
  logic rd_consume, drop_inc, repeat_inc, wr_ovr, rd_ovr;

  assign wr_edge = wr_if.load & ~wr_load_q;
  assign rd_edge = rd_if.load & ~rd_load_q;

  function automatic logic [SEC_WIDTH-1:0] next_sec(input logic [SEC_WIDTH-1:0] s);
    return (s == SEC_WIDTH'(NUM_SEC - 1)) ? '0 : s + SEC_WIDTH'(1);
  endfunction

  function automatic logic [CNT_WIDTH-1:0] sat_add(input logic [CNT_WIDTH-1:0] c,
                                                   input logic [1:0]           inc);
    logic [CNT_WIDTH:0] sum;
    sum = {1'b0, c} + (CNT_WIDTH+1)'(inc);
    return sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : sum[CNT_WIDTH-1:0];
  endfunction

  // State, section and event-flag registers
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      wr_state_q   <= W_IDLE;
      rd_state_q   <= R_IDLE;
      wr_sec_q     <= '0;
      rd_sec_q     <= SEC_WIDTH'(NUM_SEC - 1);
      last_sec_q   <= '0;
      any_done_q   <= 1'b0;
      fresh_q      <= 1'b0;
      wr_valid_q   <= 1'b0;
      rd_valid_q   <= 1'b0;
      wr_load_q    <= 1'b0;
      rd_load_q    <= 1'b0;
      drop_cnt_q   <= '0;
      repeat_cnt_q <= '0;
      ovr_cnt_q    <= '0;
    end else begin
      wr_state_q   <= wr_state_d;
      rd_state_q   <= rd_state_d;
      wr_sec_q     <= wr_sec_d;
      rd_sec_q     <= rd_sec_d;
      last_sec_q   <= last_sec_d;
      any_done_q   <= any_done_d;
      fresh_q      <= fresh_d;
      wr_valid_q   <= wr_valid_d;
      rd_valid_q   <= rd_valid_d;
      wr_load_q    <= wr_if.load;
      rd_load_q    <= rd_if.load;
      drop_cnt_q   <= drop_cnt_d;
      repeat_cnt_q <= repeat_cnt_d;
      ovr_cnt_q    <= ovr_cnt_d;
    end
  end

  // Next-state logic; the reader is resolved first so the writer can avoid its next section
  always_comb begin
    wr_state_d   = wr_state_q;
    rd_state_d   = rd_state_q;
    wr_sec_d     = wr_sec_q;
    rd_sec_d     = rd_sec_q;
    last_sec_d   = last_sec_q;
    any_done_d   = any_done_q;
    fresh_d      = fresh_q;
    rd_consume   = 1'b0;
    drop_inc     = 1'b0;
    repeat_inc   = 1'b0;
    wr_ovr       = 1'b0;
    rd_ovr       = 1'b0;

    unique case (rd_state_q)
      R_IDLE: begin
        if (rd_edge && any_done_q) begin
          rd_state_d = R_REQ;
          if (fresh_q) begin
            rd_sec_d   = last_sec_q;
            rd_consume = 1'b1;
            fresh_d    = 1'b0;
          end else begin
            repeat_inc = 1'b1;
          end
        end
      end
      R_REQ: begin
        rd_ovr = rd_edge;
        if (rd_if.desc_ready) rd_state_d = R_BUSY;
      end
      R_BUSY: begin
        rd_ovr = rd_edge;
        if (rd_if.done) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase

    unique case (wr_state_q)
      W_IDLE: begin
        if (wr_edge) wr_state_d = W_REQ;
      end
      W_REQ: begin
        wr_ovr = wr_edge;
        if (wr_if.desc_ready) wr_state_d = W_BUSY;
      end
      W_BUSY: begin
        wr_ovr = wr_edge;
        if (wr_if.done) begin
          wr_state_d = W_IDLE;
          last_sec_d = wr_sec_q;
          any_done_d = 1'b1;
          fresh_d    = 1'b1;
          drop_inc   = fresh_q & ~rd_consume;
          wr_sec_d   = next_sec(wr_sec_q);
          if (wr_sec_d == rd_sec_d && rd_state_d != R_IDLE) wr_sec_d = next_sec(wr_sec_d);
        end
      end
      default: wr_state_d = W_IDLE;
    endcase

    wr_valid_d   = (wr_state_d == W_REQ);
    rd_valid_d   = (rd_state_d == R_REQ);
    drop_cnt_d   = sat_add(drop_cnt_q, {1'b0, drop_inc});
    repeat_cnt_d = sat_add(repeat_cnt_q, {1'b0, repeat_inc});
    ovr_cnt_d    = sat_add(ovr_cnt_q, {1'b0, wr_ovr} + {1'b0, rd_ovr});
  end

  // Descriptor fields are built from registered section state only
  assign wr_if.desc_addr  = DESC_ADDR_WIDTH'({BANK_WIDTH'(BANK), wr_sec_q, {LEN_WIDTH{1'b0}}});
  assign rd_if.desc_addr  = DESC_ADDR_WIDTH'({BANK_WIDTH'(BANK), rd_sec_q, {LEN_WIDTH{1'b0}}});
  assign wr_if.desc_len   = LEN_WIDTH'(MAX_LEN);
  assign rd_if.desc_len   = LEN_WIDTH'(MAX_LEN);
  assign wr_if.desc_valid = wr_valid_q;
  assign rd_if.desc_valid = rd_valid_q;
  assign wr_if.sec        = wr_sec_q;
  assign rd_if.sec        = rd_sec_q;
  assign frame_avail      = fresh_q;
  assign drop_cnt         = drop_cnt_q;
  assign repeat_cnt       = repeat_cnt_q;
  assign ovr_cnt          = ovr_cnt_q;
endmodule

// File: tb/tb_frame_sec_mgr.sv
// Directed bench for frame_sec_mgr with NUM_SEC=4 and default frame length.
module tb_frame_sec_mgr;
  logic        aclk;
  logic        aresetn;
  logic        frame_avail;
  logic [15:0] drop_cnt, repeat_cnt, ovr_cnt;
  int          n_tests;
  int          n_fail;

  frame_sec_mgr_if #(.ADDR_W(24), .LEN_W(19), .SEC_W(2)) wr_bus ();
  frame_sec_mgr_if #(.ADDR_W(24), .LEN_W(19), .SEC_W(2)) rd_bus ();

  frame_sec_mgr dut (
    .aclk        (aclk),
    .aresetn     (aresetn),
    .wr_if       (wr_bus),
    .rd_if       (rd_bus),
    .frame_avail (frame_avail),
    .drop_cnt    (drop_cnt),
    .repeat_cnt  (repeat_cnt),
    .ovr_cnt     (ovr_cnt)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic apply_reset();
    wr_bus.load = 1'b0; wr_bus.desc_ready = 1'b0; wr_bus.done = 1'b0;
    rd_bus.load = 1'b0; rd_bus.desc_ready = 1'b0; rd_bus.done = 1'b0;
    aresetn = 1'b0;
    tick(); tick();
    aresetn = 1'b1;
    tick();
  endtask

  task automatic wr_start();  wr_bus.load = 1'b1;       tick(); wr_bus.load = 1'b0;       endtask
  task automatic wr_accept(); wr_bus.desc_ready = 1'b1; tick(); wr_bus.desc_ready = 1'b0; endtask
  task automatic wr_finish(); wr_bus.done = 1'b1;       tick(); wr_bus.done = 1'b0;       endtask
  task automatic rd_start();  rd_bus.load = 1'b1;       tick(); rd_bus.load = 1'b0;       endtask
  task automatic rd_accept(); rd_bus.desc_ready = 1'b1; tick(); rd_bus.desc_ready = 1'b0; endtask
  task automatic rd_finish(); rd_bus.done = 1'b1;       tick(); rd_bus.done = 1'b0;       endtask
  task automatic write_frame(); wr_start(); wr_accept(); wr_finish(); endtask

  task automatic test_reset();
    wr_bus.load = 1'b0; wr_bus.desc_ready = 1'b0; wr_bus.done = 1'b0;
    rd_bus.load = 1'b0; rd_bus.desc_ready = 1'b0; rd_bus.done = 1'b0;
    aresetn = 1'b0;
    tick(); tick();
    n_tests++; if (wr_bus.desc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_wr_valid got %0h want 0", wr_bus.desc_valid); end
    n_tests++; if (rd_bus.desc_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %0h want 0", rd_bus.desc_valid); end
    n_tests++; if (wr_bus.sec !== 2'd0) begin n_fail++; $display("FAIL reset_wr_sec got %0d want 0", wr_bus.sec); end
    n_tests++; if (rd_bus.sec !== 2'd3) begin n_fail++; $display("FAIL reset_rd_sec got %0d want 3", rd_bus.sec); end
    n_tests++; if (frame_avail !== 1'b0) begin n_fail++; $display("FAIL reset_avail got %0h want 0", frame_avail); end
    n_tests++; if ({drop_cnt, repeat_cnt, ovr_cnt} !== 48'd0) begin n_fail++; $display("FAIL reset_cnts got %0h want 0", {drop_cnt, repeat_cnt, ovr_cnt}); end
    n_tests++; if (wr_bus.desc_len !== 19'd518400) begin n_fail++; $display("FAIL desc_len got %0d want 518400", wr_bus.desc_len); end
    aresetn = 1'b1;
    tick();
  endtask

  task automatic test_rd_no_frame();
    rd_start();
    n_tests++; if (rd_bus.desc_valid !== 1'b0) begin n_fail++; $display("FAIL noframe_rd_valid got %0h want 0", rd_bus.desc_valid); end
    tick();
    n_tests++; if (rd_bus.desc_valid !== 1'b0) begin n_fail++; $display("FAIL noframe_rd_valid2 got %0h want 0", rd_bus.desc_valid); end
    n_tests++; if (rd_bus.sec !== 2'd3) begin n_fail++; $display("FAIL noframe_rd_sec got %0d want 3", rd_bus.sec); end
    n_tests++; if (ovr_cnt !== 16'd0) begin n_fail++; $display("FAIL noframe_ovr got %0d want 0", ovr_cnt); end
  endtask

  task automatic test_first_write();
    wr_start();
    n_tests++; if (wr_bus.desc_valid !== 1'b1) begin n_fail++; $display("FAIL first_wr_valid got %0h want 1", wr_bus.desc_valid); end
    n_tests++; if (wr_bus.desc_addr !== 24'h000000) begin n_fail++; $display("FAIL first_wr_addr got %0h want 0", wr_bus.desc_addr); end
    wr_accept();
    n_tests++; if (wr_bus.desc_valid !== 1'b0) begin n_fail++; $display("FAIL first_wr_valid_drop got %0h want 0", wr_bus.desc_valid); end
    wr_finish();
    n_tests++; if (wr_bus.sec !== 2'd1) begin n_fail++; $display("FAIL first_wr_sec got %0d want 1", wr_bus.sec); end
    n_tests++; if (frame_avail !== 1'b1) begin n_fail++; $display("FAIL first_avail got %0h want 1", frame_avail); end
    n_tests++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL first_drop got %0d want 0", drop_cnt); end
  endtask

  task automatic test_read_repeat();
    rd_start();
    n_tests++; if (rd_bus.desc_valid !== 1'b1) begin n_fail++; $display("FAIL read_valid got %0h want 1", rd_bus.desc_valid); end
    n_tests++; if (rd_bus.desc_addr !== 24'h000000) begin n_fail++; $display("FAIL read_addr got %0h want 0", rd_bus.desc_addr); end
    n_tests++; if (frame_avail !== 1'b0) begin n_fail++; $display("FAIL read_avail got %0h want 0", frame_avail); end
    rd_accept(); rd_finish();
    rd_start();
    n_tests++; if (rd_bus.desc_valid !== 1'b1) begin n_fail++; $display("FAIL repeat_valid got %0h want 1", rd_bus.desc_valid); end
    n_tests++; if (rd_bus.sec !== 2'd0) begin n_fail++; $display("FAIL repeat_sec got %0d want 0", rd_bus.sec); end
    n_tests++; if (repeat_cnt !== 16'd1) begin n_fail++; $display("FAIL repeat_cnt got %0d want 1", repeat_cnt); end
    rd_accept(); rd_finish();
  endtask

  task automatic test_skip();
    apply_reset();
    write_frame(); write_frame(); write_frame();
    n_tests++; if (wr_bus.sec !== 2'd3) begin n_fail++; $display("FAIL skip_pre_wr_sec got %0d want 3", wr_bus.sec); end
    rd_start(); rd_accept();
    n_tests++; if (rd_bus.sec !== 2'd2) begin n_fail++; $display("FAIL skip_rd_sec got %0d want 2", rd_bus.sec); end
    write_frame();
    n_tests++; if (wr_bus.sec !== 2'd0) begin n_fail++; $display("FAIL skip_wrap_sec got %0d want 0", wr_bus.sec); end
    write_frame();
    wr_start();
    n_tests++; if (wr_bus.desc_addr !== 24'h080000) begin n_fail++; $display("FAIL skip_wr_addr got %0h want 80000", wr_bus.desc_addr); end
    wr_accept(); wr_finish();
    n_tests++; if (wr_bus.sec !== 2'd3) begin n_fail++; $display("FAIL skip_wr_sec got %0d want 3", wr_bus.sec); end
    n_tests++; if (drop_cnt !== 16'd4) begin n_fail++; $display("FAIL skip_drop got %0d want 4", drop_cnt); end
    rd_finish();
  endtask

  task automatic test_drop_ovr();
    apply_reset();
    wr_finish();
    n_tests++; if (wr_bus.sec !== 2'd0 || frame_avail !== 1'b0) begin n_fail++; $display("FAIL idle_done got sec=%0d avail=%0h want sec=0 avail=0", wr_bus.sec, frame_avail); end
    write_frame(); write_frame();
    n_tests++; if (drop_cnt !== 16'd1) begin n_fail++; $display("FAIL drop_cnt got %0d want 1", drop_cnt); end
    wr_start(); wr_accept();
    wr_start();
    n_tests++; if (ovr_cnt !== 16'd1) begin n_fail++; $display("FAIL ovr_cnt got %0d want 1", ovr_cnt); end
    tick();
    wr_finish();
    tick();
    n_tests++; if (wr_bus.desc_valid !== 1'b0) begin n_fail++; $display("FAIL ovr_no_desc got %0h want 0", wr_bus.desc_valid); end
    n_tests++; if (drop_cnt !== 16'd2) begin n_fail++; $display("FAIL drop_cnt2 got %0d want 2", drop_cnt); end
  endtask

  task automatic test_simul_and_reset();
    apply_reset();
    write_frame();
    wr_start(); wr_accept();
    rd_bus.load = 1'b1; wr_bus.done = 1'b1;
    tick();
    rd_bus.load = 1'b0; wr_bus.done = 1'b0;
    n_tests++; if (rd_bus.sec !== 2'd0) begin n_fail++; $display("FAIL simul_rd_sec got %0d want 0", rd_bus.sec); end
    n_tests++; if (frame_avail !== 1'b1) begin n_fail++; $display("FAIL simul_avail got %0h want 1", frame_avail); end
    n_tests++; if (drop_cnt !== 16'd0) begin n_fail++; $display("FAIL simul_drop got %0d want 0", drop_cnt); end
    n_tests++; if (wr_bus.sec !== 2'd2) begin n_fail++; $display("FAIL simul_wr_sec got %0d want 2", wr_bus.sec); end
    rd_accept();
    rd_start();
    n_tests++; if (ovr_cnt !== 16'd1) begin n_fail++; $display("FAIL rd_ovr got %0d want 1", ovr_cnt); end
    aresetn = 1'b0;
    #1;
    n_tests++; if (rd_bus.sec !== 2'd3 || wr_bus.sec !== 2'd0) begin n_fail++; $display("FAIL midrst_secs got rd=%0d wr=%0d want rd=3 wr=0", rd_bus.sec, wr_bus.sec); end
    n_tests++; if (frame_avail !== 1'b0 || ovr_cnt !== 16'd0) begin n_fail++; $display("FAIL midrst_state got avail=%0h ovr=%0d want 0 0", frame_avail, ovr_cnt); end
    tick();
    aresetn = 1'b1;
    rd_finish();
    tick();
    n_tests++; if (rd_bus.desc_valid !== 1'b0 || wr_bus.desc_valid !== 1'b0) begin n_fail++; $display("FAIL postrst_valids got rd=%0h wr=%0h want 0 0", rd_bus.desc_valid, wr_bus.desc_valid); end
    rd_start();
    n_tests++; if (rd_bus.desc_valid !== 1'b0) begin n_fail++; $display("FAIL postrst_no_frame got %0h want 0", rd_bus.desc_valid); end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_rd_no_frame();
    test_first_write();
    test_read_repeat();
    test_skip();
    test_drop_ovr();
    test_simul_and_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/frame_sec_mgr.md
FRAME_SEC_MGR -- requirements
Module: frame_sec_mgr

Interface
REQ-001 SHALL have parameter NUM_SEC, default 4, number of frame sections in DDR (legal 3..16).
REQ-002 SHALL have parameter MAX_LEN, default 518400, frame length in descriptor units.
REQ-003 SHALL have parameter LEN_WIDTH, default $clog2(MAX_LEN), length field and section-offset width.
REQ-004 SHALL have parameter BANK_WIDTH, default 3, and parameter BANK, default 0, the fixed bank field.
REQ-005 SHALL derive localparams SEC_WIDTH = $clog2(NUM_SEC) and DESC_ADDR_WIDTH = BANK_WIDTH+SEC_WIDTH+LEN_WIDTH.
REQ-006 SHALL use one clock and an asynchronous active-low reset; ports below are listed clock and reset first.
REQ-007 aclk  in  1  sole clock; all logic on rising edge.
REQ-008 aresetn  in  1  asynchronous active-low reset.
REQ-009 wr_load / rd_load  in  1 each  frame-start levels, synchronous to aclk; only the rising edge acts.
REQ-010 wr_desc_addr / rd_desc_addr  out  DESC_ADDR_WIDTH each  {BANK, section, LEN_WIDTH zeros}.
REQ-011 wr_desc_len / rd_desc_len  out  LEN_WIDTH each  constant MAX_LEN.
REQ-012 wr_desc_valid / rd_desc_valid  out  1; wr_desc_ready / rd_desc_ready  in  1  descriptor handshakes.
REQ-013 wr_done / rd_done  in  1 each  one-cycle DMA frame-complete pulses.
REQ-014 wr_sec / rd_sec  out  SEC_WIDTH each  current write and read sections.
REQ-015 frame_avail  out  1  a completed frame exists and is unread.
REQ-016 drop_cnt, repeat_cnt, ovr_cnt  out  16 each  saturating event counters.

Function
REQ-017 Writer FSM SHALL have states W_IDLE, W_REQ, W_BUSY: W_IDLE->W_REQ on wr_load edge; W_REQ->W_BUSY on valid&ready; W_BUSY->W_IDLE on wr_done.
REQ-018 Reader FSM SHALL have states R_IDLE, R_REQ, R_BUSY with the same transitions, using rd_* signals.
REQ-019 wr_desc_valid SHALL be high exactly in W_REQ, and rd_desc_valid exactly in R_REQ; addresses SHALL stay stable while valid.
REQ-020 A load edge outside the IDLE state SHALL be ignored and SHALL increment ovr_cnt.
REQ-021 The first descriptor SHALL be issued with valid asserted one cycle after the load edge is sampled.
REQ-022 On wr_done in W_BUSY: last_sec <= wr_sec, any_done <= 1, fresh <= 1.
REQ-023 On wr_done, if fresh was 1 and was not consumed in the same cycle, drop_cnt SHALL increment.
REQ-024 On wr_done, the next wr_sec SHALL be c = (wr_sec+1) mod NUM_SEC; if c equals the reader's next-state section with reader not next-state idle, it SHALL be (c+1) mod NUM_SEC.
REQ-025 On rd_load edge in R_IDLE with any_done=0, the reader SHALL stay idle and no descriptor SHALL be issued.
REQ-026 On rd_load edge in R_IDLE with any_done=1: rd_sec <= last_sec and fresh cleared if fresh=1; otherwise rd_sec is unchanged and repeat_cnt increments.
REQ-027 If the read latch and wr_done occur in the same cycle, the reader SHALL take the pre-update last_sec, and fresh SHALL end at 1.
REQ-028 The writer SHALL never hold the section the reader is in R_REQ/R_BUSY on.
REQ-029 frame_avail SHALL equal fresh.
REQ-030 All counters SHALL saturate at 16'hFFFF.
REQ-031 done pulses outside BUSY SHALL be ignored.

Reset
REQ-032 On aresetn low, state SHALL be W_IDLE/R_IDLE, wr_sec=0, rd_sec=NUM_SEC-1, last_sec=0, any_done=0, fresh=0, valids 0, counters 0, edge-detect registers 0.
REQ-033 Reset mid-transfer SHALL abandon descriptors immediately, with no pending state retained.

Verification
REQ-034 Reset, then rd_load edge -> no rd_desc_valid, rd_sec=3.
REQ-035 wr_load edge, ready next cycle, wr_done -> wr_desc_addr={3'b000,2'd0,19'd0}, wr_sec=1, frame_avail=1.
REQ-036 Then rd_load edge -> rd_desc_addr section 0, frame_avail=0; second read without a new write -> section 0 again, repeat_cnt=1.
REQ-037 Reader busy on section 2 while the writer completes section 1 -> wr_sec skips to 3.
REQ-038 Two writes with no read -> drop_cnt=1; wr_load during W_BUSY -> ovr_cnt=1, no extra descriptor.
REQ-039 Simultaneous rd latch and wr_done -> reader takes the old section, frame_avail=1, drop_cnt unchanged; aresetn low mid-R_BUSY -> all reset values next cycle.
